// File: rtl/mirfak_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the EX stage.
// Stalls the pipeline through busy_o and holds its result until the EX/WB register takes it.
module mirfak_divider #(
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        div_op_i,
    input  logic [1:0]  div_type_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        ex_enable_i,
    input  logic        kill_i,
    output logic        busy_o,
    output logic [31:0] result_o,
    output logic        done_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        is_rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        div_zero_q;
    logic [31:0] divisor_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] result_q;
    logic [4:0]  count_q;

    logic        start;
    logic        is_signed;
    logic        div_zero_in;
    logic        overflow_in;
    logic        fast_hit;
    logic [31:0] dividend_abs;
    logic [31:0] divisor_abs;
    logic [31:0] special_result;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] rem_step;
    logic [31:0] quo_step;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] final_result;

    assign start        = div_op_i && !kill_i;
    assign is_signed    = !div_type_i[0];
    assign div_zero_in  = (divisor_i == 32'd0);
    assign overflow_in  = is_signed && (dividend_i == 32'h8000_0000) && (divisor_i == 32'hFFFF_FFFF);
    assign fast_hit     = FAST_SPECIAL && (div_zero_in || overflow_in);
    assign dividend_abs = (is_signed && dividend_i[31]) ? -dividend_i : dividend_i;
    assign divisor_abs  = (is_signed && divisor_i[31])  ? -divisor_i  : divisor_i;

    always_comb begin
        special_result = 32'd0;
        if (div_type_i[1]) begin
            special_result = div_zero_in ? dividend_i : 32'd0;
        end else begin
            special_result = div_zero_in ? 32'hFFFF_FFFF : 32'h8000_0000;
        end
    end

    // One restoring step: a zero divisor naturally yields all-ones quotient and |dividend| remainder.
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, divisor_q};
    assign rem_step = diff[32] ? shifted[31:0] : diff[31:0];
    assign quo_step = {quo_q[30:0], !diff[32]};

    assign quo_fix      = (neg_quo_q && !div_zero_q) ? -quo_step : quo_step;
    assign rem_fix      = neg_rem_q ? -rem_step : rem_step;
    assign final_result = is_rem_q ? rem_fix : quo_fix;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = fast_hit ? DONE : CALC;
                end
            end
            CALC: begin
                if (count_q == 5'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ex_enable_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (kill_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            is_rem_q   <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            divisor_q  <= 32'd0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            result_q   <= 32'd0;
            count_q    <= 5'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_rem_q   <= div_type_i[1];
                        neg_quo_q  <= is_signed && (dividend_i[31] ^ divisor_i[31]);
                        neg_rem_q  <= is_signed && dividend_i[31];
                        div_zero_q <= div_zero_in;
                        divisor_q  <= divisor_abs;
                        quo_q      <= dividend_abs;
                        rem_q      <= 32'd0;
                        count_q    <= 5'd31;
                        if (fast_hit) begin
                            result_q <= special_result;
                        end
                    end
                end
                CALC: begin
                    if (!kill_i) begin
                        rem_q   <= rem_step;
                        quo_q   <= quo_step;
                        count_q <= count_q - 5'd1;
                        if (count_q == 5'd0) begin
                            result_q <= final_result;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational so the stall lands in the very cycle the divide enters EX.
    assign busy_o   = div_op_i && !kill_i && (state_q != DONE);
    assign done_o   = (state_q == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_mirfak_divider.sv
// Bench for mirfak_divider: two instances (fast and iterative special cases) driven
// by directed and random divides, checked by a scoreboard against an arithmetic model.
module tb_mirfak_divider;

    logic        clk;
    logic        rst_n;
    logic        div_op   [2];
    logic [1:0]  div_type [2];
    logic [31:0] dividend [2];
    logic [31:0] divisor  [2];
    logic        ex_en    [2];
    logic        kill     [2];
    logic        busy     [2];
    logic        done     [2];
    logic [31:0] result   [2];
    logic        prev_busy[2];

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];

    int checks = 0;
    int errors = 0;

    mirfak_divider #(.FAST_SPECIAL(1'b1)) dut_fast (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .div_op_i   (div_op[0]),
        .div_type_i (div_type[0]),
        .dividend_i (dividend[0]),
        .divisor_i  (divisor[0]),
        .ex_enable_i(ex_en[0]),
        .kill_i     (kill[0]),
        .busy_o     (busy[0]),
        .result_o   (result[0]),
        .done_o     (done[0])
    );

    mirfak_divider #(.FAST_SPECIAL(1'b0)) dut_slow (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .div_op_i   (div_op[1]),
        .div_type_i (div_type[1]),
        .dividend_i (dividend[1]),
        .divisor_i  (divisor[1]),
        .ex_enable_i(ex_en[1]),
        .kill_i     (kill[1]),
        .busy_o     (busy[1]),
        .result_o   (result[1]),
        .done_o     (done[1])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural RV32M results, straight from the ISA definition.
    function automatic logic [31:0] ref_model(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (!t[0]) begin
            q = sa / sb;
            r = sa % sb;
        end else begin
            q = a / b;
            r = a % b;
        end
        return t[1] ? r : q;
    endfunction

    function automatic int exp_busy_len(input int inst, input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
        bit special;
        special = (b == 32'd0) || (!t[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        return (inst == 0 && special) ? 1 : 33;
    endfunction

    // driver tasks
    task automatic run_div(input int inst, input logic [1:0] t, input logic [31:0] a,
                           input logic [31:0] b, input int stall, input bit b2b);
        logic [31:0] e;
        int n;
        int want_busy;
        e = ref_model(t, a, b);
        want_busy = exp_busy_len(inst, t, a, b);
        if (inst == 0) exp_q0.push_back(e);
        else exp_q1.push_back(e);
        @(negedge clk);
        div_op[inst]   = 1'b1;
        div_type[inst] = t;
        dividend[inst] = a;
        divisor[inst]  = b;
        ex_en[inst]    = 1'b0;
        kill[inst]     = 1'b0;
        n = 0;
        #1;
        while (busy[inst] && n < 100) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("busy_len", n, want_busy);
        check("done_rise", {31'd0, done[inst]}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_done", {31'd0, done[inst]}, 32'd1);
            check("stall_busy", {31'd0, busy[inst]}, 32'd0);
            check("stall_result", result[inst], e);
            @(negedge clk);
            #1;
        end
        ex_en[inst] = 1'b1;
        if (!b2b) begin
            @(negedge clk);
            div_op[inst] = 1'b0;
            ex_en[inst]  = 1'b0;
            #1;
            check("idle_after_accept", {31'd0, done[inst]}, 32'd0);
        end
    endtask

    task automatic run_kill();
        @(negedge clk);
        div_op[0]   = 1'b1;
        div_type[0] = 2'b01;
        dividend[0] = $urandom;
        divisor[0]  = $urandom_range(1, 1000);
        ex_en[0]    = 1'b0;
        repeat (10) @(negedge clk);
        kill[0] = 1'b1;
        #1;
        check("kill_busy", {31'd0, busy[0]}, 32'd0);
        check("kill_done", {31'd0, done[0]}, 32'd0);
        run_div(0, 2'b01, 32'd9, 32'd3, 0, 1'b0);
    endtask

    task automatic run_reset();
        @(negedge clk);
        div_op[0]   = 1'b1;
        div_type[0] = 2'b01;
        dividend[0] = 32'd12345;
        divisor[0]  = 32'd7;
        ex_en[0]    = 1'b0;
        repeat (20) @(negedge clk);
        rst_n     = 1'b0;
        div_op[0] = 1'b0;
        @(negedge clk);
        #1;
        check("rst_busy", {31'd0, busy[0]}, 32'd0);
        check("rst_done", {31'd0, done[0]}, 32'd0);
        check("rst_result", result[0], 32'd0);
        rst_n = 1'b1;
        run_div(0, 2'b01, 32'hFFFF_FFFF, 32'd1, 0, 1'b1);
        run_div(0, 2'b01, 32'd6, 32'd4, 0, 1'b0);
    endtask

    // scoreboard monitor: pops an expected value whenever a result is accepted
    task automatic monitor_step(input int i);
        logic [31:0] e;
        int qsize;
        if (!rst_n) return;
        qsize = (i == 0) ? exp_q0.size() : exp_q1.size();
        if (done[i] && qsize == 0) begin
            check("unexpected_done", {31'd0, done[i]}, 32'd0);
        end else if (done[i] && ex_en[i]) begin
            e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            check(i == 0 ? "result_fast" : "result_slow", result[i], e);
        end
        if (prev_busy[i] && !div_op[i] && !kill[i]) begin
            errors++;
            $display("FAIL div_op_drop: inst %0d dropped div_op while busy", i);
        end
    endtask

    always @(negedge clk) begin
        #3;
        monitor_step(0);
        monitor_step(1);
        prev_busy[0] = rst_n && busy[0];
        prev_busy[1] = rst_n && busy[1];
    end

    initial begin
        int inst;
        int sel;
        logic [1:0]  t;
        logic [31:0] a;
        logic [31:0] b;
        rst_n = 1'b0;
        prev_busy[0] = 1'b0;
        prev_busy[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            div_op[i]   = 1'b0;
            div_type[i] = 2'b00;
            dividend[i] = 32'd0;
            divisor[i]  = 32'd0;
            ex_en[i]    = 1'b0;
            kill[i]     = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("reset_busy", {31'd0, busy[i]}, 32'd0);
            check("reset_done", {31'd0, done[i]}, 32'd0);
            check("reset_result", result[i], 32'd0);
        end
        rst_n = 1'b1;

        run_div(0, 2'b01, 32'd100, 32'd7, 0, 1'b0);
        run_div(0, 2'b11, 32'd100, 32'd7, 0, 1'b0);
        run_div(0, 2'b00, -32'sd7, 32'd2, 0, 1'b0);
        run_div(0, 2'b10, -32'sd7, 32'd2, 0, 1'b0);
        run_div(0, 2'b00, 32'd7, -32'sd2, 0, 1'b0);
        run_div(0, 2'b10, 32'd7, -32'sd2, 0, 1'b0);
        run_div(0, 2'b00, 32'd5, 32'd0, 0, 1'b0);
        run_div(0, 2'b11, 32'd5, 32'd0, 0, 1'b0);
        run_div(0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(1, 2'b00, 32'd5, 32'd0, 0, 1'b0);
        run_div(1, 2'b11, 32'd5, 32'd0, 0, 1'b0);
        run_div(1, 2'b10, -32'sd5, 32'd0, 0, 1'b0);
        run_div(1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_div(0, 2'b01, 32'd1000, 32'd10, 5, 1'b0);
        run_kill();
        run_reset();

        for (int k = 0; k < 30; k++) begin
            inst = $urandom_range(0, 1);
            t    = 2'($urandom_range(0, 3));
            sel  = $urandom_range(0, 5);
            a    = $urandom;
            case (sel)
                0: b = $urandom;
                1: b = $urandom_range(1, 50);
                2: b = 32'd0;
                3: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: b = ($urandom_range(0, 1) == 0) ? 32'd1 : 32'hFFFF_FFFF;
                default: begin a = $urandom_range(0, 200); b = -($urandom_range(1, 20)); end
            endcase
            run_div(inst, t, a, b, $urandom_range(0, 2), 1'b0);
        end

        repeat (3) @(negedge clk);
        check("queue_empty_fast", exp_q0.size(), 32'd0);
        check("queue_empty_slow", exp_q1.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
